// File: rtl/bram_arb_pkg.sv
// Shared definitions for the BRAM port arbiter: default geometry,
// lock-FSM state encoding and a one-hot to index helper.
package bram_arb_pkg;

   localparam int DEFAULT_WIDTH  = 72;
   localparam int DEFAULT_ADDR_W = 9;
   localparam int DEFAULT_N_REQ  = 4;
   localparam int DEFAULT_ID_W   = 2;

   localparam logic [0:0] ST_OPEN   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   // Converts a one-hot vector of up to 8 requesters into its bit index
   function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (onehot[i]) begin
            idx = 3'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating priority arbiter: the search starts at ptr and wraps modulo N,
// the first active request wins. Produces a one-hot grant and its index.
// A zero ptr turns this into a plain lowest-index-wins priority encoder.
module rr_arbiter
   import bram_arb_pkg::*;
#(
   parameter int N    = DEFAULT_N_REQ,
   parameter int ID_W = DEFAULT_ID_W
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_idx,
   output logic            grant_any
);

   // Walk the requesters starting at ptr and grant the first one found
   always_comb begin
      logic            found;
      logic [ID_W:0]   sum;
      logic [ID_W-1:0] pos;
      grant = '0;
      found = 1'b0;
      sum   = '0;
      pos   = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr} + (ID_W+1)'(i);
         if (sum >= (ID_W+1)'(N)) begin
            sum = sum - (ID_W+1)'(N);
         end
         pos = sum[ID_W-1:0];
         if (!found && req[pos]) begin
            grant[pos] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign grant_idx = ID_W'(onehot_to_idx(8'(grant)));
   assign grant_any = |grant;

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between N_REQ valid/ready requesters. One request
// is accepted per cycle, registered onto the BRAM port the next cycle, and
// read data comes back to the winner two cycles after its accept.
// A requester holding req_lock keeps the port for a burst.
// Build option: define BRAM_ARB_FIXED_PRIO_EN for fixed lowest-index
// priority instead of round-robin (the rotating pointer is then removed).
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int N_REQ  = DEFAULT_N_REQ,
   parameter int ID_W   = DEFAULT_ID_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_we,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*WIDTH-1:0]  req_wdata,
   input  logic [N_REQ-1:0]        req_lock,
   output logic [N_REQ-1:0]        req_ready,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [WIDTH-1:0]        rsp_rdata,
   output logic [ADDR_W-1:0]       bram_addr,
   output logic [WIDTH-1:0]        bram_wdata,
   output logic                    bram_we,
   input  logic [WIDTH-1:0]        bram_rdata
);

   logic [0:0]        state;
   logic [ID_W-1:0]   owner;
   logic [ID_W-1:0]   arb_ptr;
   logic [N_REQ-1:0]  owner_mask;
   logic [N_REQ-1:0]  arb_req;
   logic [N_REQ-1:0]  grant;
   logic [ID_W-1:0]   grant_idx;
   logic              grant_any;
   logic              accept;
   logic              owner_hold;
   logic [ADDR_W-1:0] win_addr;
   logic [WIDTH-1:0]  win_wdata;
   logic              win_we;
   logic              win_lock;
   logic              pend_valid;
   logic [ID_W-1:0]   pend_idx;

   // While locked and the owner still wants the burst, everyone else is masked
   assign owner_mask = N_REQ'(1) << owner;
   assign owner_hold = (state == ST_LOCKED) && req_valid[owner] && req_lock[owner];
   assign arb_req    = owner_hold ? (req_valid & owner_mask) : req_valid;

   rr_arbiter #(
      .N    (N_REQ),
      .ID_W (ID_W)
   ) u_arb (
      .req       (arb_req),
      .ptr       (arb_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // Ready is suppressed during reset so outputs read zero asynchronously
   assign accept    = grant_any & ~rst;
   assign req_ready = accept ? grant : '0;

   assign win_addr  = req_addr[grant_idx*ADDR_W +: ADDR_W];
   assign win_wdata = req_wdata[grant_idx*WIDTH +: WIDTH];
   assign win_we    = req_we[grant_idx];
   assign win_lock  = req_lock[grant_idx];

`ifdef BRAM_ARB_FIXED_PRIO_EN
   assign arb_ptr = '0;
`else
   logic [ID_W-1:0] rr_ptr;

   // Rotate priority past the winner; a burst grant leaves the pointer alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (accept && !owner_hold) begin
         rr_ptr <= (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
   end

   assign arb_ptr = rr_ptr;
`endif

   // Lock FSM: enter LOCKED when the winner asks for a burst, leave when it lets go
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_OPEN;
         owner <= '0;
      end else if (accept) begin
         if (win_lock) begin
            state <= ST_LOCKED;
            owner <= grant_idx;
         end else begin
            state <= ST_OPEN;
         end
      end else begin
         state <= ST_OPEN;
      end
   end

   // Register the winner's request onto the BRAM port; idle cycles hold the address
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bram_addr  <= '0;
         bram_wdata <= '0;
         bram_we    <= 1'b0;
      end else if (accept) begin
         bram_addr  <= win_addr;
         bram_wdata <= win_wdata;
         bram_we    <= win_we;
      end else begin
         bram_we    <= 1'b0;
      end
   end

   // Two-stage read tracker: stage one is the BRAM access, stage two the returned data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_valid <= 1'b0;
         pend_idx   <= '0;
         rsp_valid  <= '0;
      end else begin
         pend_valid <= accept && !win_we;
         pend_idx   <= grant_idx;
         rsp_valid  <= pend_valid ? (N_REQ'(1) << pend_idx) : '0;
      end
   end

   assign rsp_rdata = bram_rdata;

endmodule
